// File: rtl/m_pcpi_arbiter_pkg.sv
// Shared types and constants for the PCPI coprocessor arbiter.
package m_pcpi_arbiter_pkg;

  localparam int ARB_TIMEOUT = 16;

  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ARB_IDLE    = 2'd0;
  localparam arb_state_t ARB_ISSUE   = 2'd1;
  localparam arb_state_t ARB_RESP    = 2'd2;
  localparam arb_state_t ARB_RELEASE = 2'd3;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } pcpi_txn_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] rd;
    logic        timeout;
  } pcpi_rsp_t;

endpackage

// File: rtl/m_rr_picker.sv
// Combinational round-robin picker: first set request after ptr_i, wrapping.
// Returns a one-hot grant, its binary index and an any-request flag.
module m_rr_picker #(
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  always_comb begin
    int j;
    j       = 0;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    // Offset 1 first so the previous winner has the lowest priority.
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(ptr_i) + k) % NREQ;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        grant_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/m_pcpi_arbiter.sv
// Round-robin sharing of one PCPI coprocessor among NREQ requesters, with an
// unclaimed-instruction timeout. All outputs are registered.
module m_pcpi_arbiter
  import m_pcpi_arbiter_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = ARB_TIMEOUT,
  localparam int CW     = $clog2(TIMEOUT + 1),
  localparam int IW     = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NREQ-1:0]      req_valid_i,
  input  logic [NREQ*32-1:0]   req_insn_i,
  input  logic [NREQ*32-1:0]   req_rs1_i,
  input  logic [NREQ*32-1:0]   req_rs2_i,
  output logic [NREQ-1:0]      rsp_valid_o,
  output logic                 rsp_wr_o,
  output logic [31:0]          rsp_rd_o,
  output logic                 rsp_timeout_o,
  output logic [NREQ-1:0]      req_busy_o,
  output logic                 pcpi_valid_o,
  output logic [31:0]          pcpi_insn_o,
  output logic [31:0]          pcpi_rs1_o,
  output logic [31:0]          pcpi_rs2_o,
  input  logic                 pcpi_ready_i,
  input  logic                 pcpi_wr_i,
  input  logic [31:0]          pcpi_rd_i,
  input  logic                 pcpi_busy_i
);

  arb_state_t      state_q, state_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  pcpi_txn_t       txn_q, txn_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pcpi_valid_q, pcpi_valid_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  pcpi_rsp_t       rsp_q, rsp_d;
  logic [NREQ-1:0] req_busy_q, req_busy_d;

  logic [NREQ-1:0] pick_grant;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;

  m_rr_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_picker (
    .req_i   (req_valid_i),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    txn_d        = txn_q;
    cnt_d        = cnt_q;
    pcpi_valid_d = pcpi_valid_q;
    req_busy_d   = req_busy_q;
    rsp_valid_d  = '0;
    rsp_d        = '0;

    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d      = ARB_ISSUE;
          grant_d      = pick_idx;
          rr_ptr_d     = pick_idx;
          txn_d.insn   = req_insn_i[32*pick_idx +: 32];
          txn_d.rs1    = req_rs1_i[32*pick_idx +: 32];
          txn_d.rs2    = req_rs2_i[32*pick_idx +: 32];
          cnt_d        = '0;
          pcpi_valid_d = 1'b1;
          req_busy_d   = pick_grant;
        end
      end

      ARB_ISSUE: begin
        // A claim arriving on the final timeout cycle still wins.
        if (pcpi_ready_i) begin
          state_d              = ARB_RESP;
          pcpi_valid_d         = 1'b0;
          req_busy_d           = '0;
          cnt_d                = '0;
          rsp_valid_d[grant_q] = 1'b1;
          rsp_d.wr             = pcpi_wr_i;
          rsp_d.rd             = pcpi_rd_i;
        end else if (pcpi_busy_i) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d              = ARB_RESP;
          pcpi_valid_d         = 1'b0;
          req_busy_d           = '0;
          cnt_d                = '0;
          rsp_valid_d[grant_q] = 1'b1;
          rsp_d.timeout        = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ARB_RESP: begin
        state_d = ARB_RELEASE;
      end

      default: begin
        // Requester drops req_valid this cycle; IDLE samples afterwards.
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ARB_IDLE;
      grant_q      <= '0;
      rr_ptr_q     <= IW'(NREQ - 1);
      txn_q        <= '0;
      cnt_q        <= '0;
      pcpi_valid_q <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_q        <= '0;
      req_busy_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      txn_q        <= txn_d;
      cnt_q        <= cnt_d;
      pcpi_valid_q <= pcpi_valid_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_q        <= rsp_d;
      req_busy_q   <= req_busy_d;
    end
  end

  assign pcpi_valid_o  = pcpi_valid_q;
  assign pcpi_insn_o   = txn_q.insn;
  assign pcpi_rs1_o    = txn_q.rs1;
  assign pcpi_rs2_o    = txn_q.rs2;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_wr_o      = rsp_q.wr;
  assign rsp_rd_o      = rsp_q.rd;
  assign rsp_timeout_o = rsp_q.timeout;
  assign req_busy_o    = req_busy_q;

endmodule
